dht_reader: RTL
===============

DHT_READER -- requirements
Module: dht_reader

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000: clock frequency; CLK_HZ/1_000_000 SHALL be an integer >= 2.
REQ-002 Parameter NBYTES, default 5: frame length in bytes; the last byte is the checksum; range 2..8.
REQ-003 Parameter START_LOW_US, default 18000: host start-pulse low time.
REQ-004 Parameter BIT_THRESH_US, default 40: high-time threshold separating bit 0 from bit 1.
REQ-005 Parameter TIMEOUT_US, default 200: maximum duration of any sensor-driven phase.
REQ-006 Parameter AUTO_PERIOD_MS, default 0: automatic retrigger period; 0 disables it.
REQ-007 clk  in  1  the single clock; all logic SHALL be on its rising edge.
REQ-008 rst  in  1  reset, synchronous and active-high.
REQ-009 start  in  1  one-cycle request to begin a read.
REQ-010 dth_in  in  1  sampled level of the open-drain DTH line.
REQ-011 dth_oe  out  1  1 = drive the line low, 0 = release it (the external pull-up gives high).
REQ-012 data_out  out  8*NBYTES  last good frame, MSB first, as received.
REQ-013 data_valid  out  1  one-cycle pulse when data_out is updated.
REQ-014 busy  out  1  high while a transaction is in progress.
REQ-015 err_timeout  out  1  sticky; set on a phase timeout.
REQ-016 err_checksum  out  1  sticky; set on a checksum mismatch.

Function
REQ-017 dth_in SHALL pass through a 2-flop synchroniser; all decisions use the synchronised value.
REQ-018 A prescaler SHALL produce a 1-cycle 1 us tick every CLK_HZ/1_000_000 clocks; every duration counter counts ticks.
REQ-019 States: IDLE, START_LOW, REL_WAIT, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK.
REQ-020 IDLE: when start=1, or the auto-period timer expires, SHALL clear both error flags, set busy and go to START_LOW; start is ignored while busy=1.
REQ-021 START_LOW: dth_oe=1 for START_LOW_US ticks, then dth_oe=0 and go to REL_WAIT.
REQ-022 REL_WAIT: on a falling edge go to RESP_LOW.
REQ-023 RESP_LOW: on a rising edge go to RESP_HIGH.
REQ-024 RESP_HIGH: on a falling edge go to BIT_LOW with the bit counter at 0.
REQ-025 BIT_LOW: on a rising edge clear the high-time counter and go to BIT_HIGH.
REQ-026 BIT_HIGH: on a falling edge, shift in 1 if the high time exceeds BIT_THRESH_US, else shift in 0, and increment the bit counter.
REQ-027 After BIT_HIGH, when the bit counter reaches 8*NBYTES go to CHECK; otherwise go to BIT_LOW.
REQ-028 In REL_WAIT through BIT_HIGH, a phase lasting longer than TIMEOUT_US ticks SHALL set err_timeout, clear busy and return to IDLE; data_out is unchanged.
REQ-029 CHECK (one cycle): compare the sum of bytes 0..NBYTES-2, modulo 256, against the last byte.
REQ-030 CHECK match: load data_out, pulse data_valid for one cycle and return to IDLE.
REQ-031 CHECK mismatch: set err_checksum, leave data_out unchanged and return to IDLE; busy SHALL clear on the IDLE entry cycle.
REQ-032 dth_oe SHALL be 1 only in START_LOW.
REQ-033 Auto timer (AUTO_PERIOD_MS>0): counts ms from each IDLE entry and fires once per period.
REQ-034 Auto timer firing together with start SHALL produce one transaction.
REQ-035 The high-time counter SHALL saturate and never wrap; the timeout fires before saturation.

Reset
REQ-036 rst=1 SHALL give: state IDLE, dth_oe=0, busy=0, data_valid=0, err_timeout=0, err_checksum=0, data_out=0, all counters and synchroniser flops=0.
REQ-037 rst asserted mid-transaction SHALL abort on the next edge, releasing the line within one cycle.

Verification (sim CLK_HZ=10_000_000, START_LOW_US=180)
REQ-038 Good frame: start, sensor gives 80/80 us response, then 40 bits (50 us low; high 27 us = 0, 70 us = 1) of 0x3A_00_19_05_58 -> data_valid pulses once, data_out=0x3A00190558, no errors.
REQ-039 Checksum error: same frame with last byte 0x59 -> err_checksum=1, data_valid=0, data_out keeps the previous value.
REQ-040 No sensor: line held high after release -> err_timeout=1 at 200 us +/- 1 tick after release, busy=0.
REQ-041 Stuck line: line held high for 300 us in bit 17 -> err_timeout=1, and the next start succeeds and clears the flag.
REQ-042 Reset mid-frame at bit 20 -> dth_oe=0, busy=0 and all outputs at reset values on the next cycle.
REQ-043 AUTO_PERIOD_MS=1 with no start -> START_LOW begins 1 ms after each IDLE entry, and start during busy is ignored.

Source files
------------

// File: rtl/dht_reader.sv
// Single-wire DHT-style sensor reader: issues the host start pulse, times the sensor
// response and data bits, validates the checksum and keeps the last good frame.
module dht_reader #(
    parameter int unsigned CLK_HZ         = 50_000_000,
    parameter int unsigned NBYTES         = 5,
    parameter int unsigned START_LOW_US   = 18000,
    parameter int unsigned BIT_THRESH_US  = 40,
    parameter int unsigned TIMEOUT_US     = 200,
    parameter int unsigned AUTO_PERIOD_MS = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  dth_in,
    output logic                  dth_oe,
    output logic [8*NBYTES-1:0]   data_out,
    output logic                  data_valid,
    output logic                  busy,
    output logic                  err_timeout,
    output logic                  err_checksum
);

    localparam int unsigned DIV       = CLK_HZ / 1_000_000;
    localparam int unsigned DW        = $clog2(DIV);
    localparam int unsigned NBITS     = 8 * NBYTES;
    localparam int unsigned BCW       = $clog2(NBITS + 1);
    localparam int unsigned LIM_A     = (START_LOW_US > TIMEOUT_US) ? START_LOW_US : TIMEOUT_US;
    localparam int unsigned LIM       = (LIM_A > BIT_THRESH_US) ? LIM_A : BIT_THRESH_US + 1;
    localparam int unsigned CW        = $clog2(LIM + 2);
    localparam int unsigned AUTO_US   = AUTO_PERIOD_MS * 1000;
    localparam int unsigned AW        = (AUTO_US > 1) ? $clog2(AUTO_US) : 1;
    localparam int unsigned AUTO_LAST = (AUTO_US > 0) ? AUTO_US - 1 : 0;

    typedef enum logic [2:0] {
        StIdle,
        StStartLow,
        StRelWait,
        StRespLow,
        StRespHigh,
        StBitLow,
        StBitHigh,
        StCheck
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          sync_q;
    logic                prev_q;
    logic [DW-1:0]       div_q, div_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [BCW-1:0]      bitcnt_q, bitcnt_d;
    logic [NBITS-1:0]    shreg_q, shreg_d;
    logic [NBITS-1:0]    data_q, data_d;
    logic [AW-1:0]       auto_q, auto_d;
    logic                valid_q, valid_d;
    logic                eto_q, eto_d;
    logic                ecs_q, ecs_d;

    logic                line, fall, rise, tick, phase_to, auto_fire, bit_val;
    logic [7:0]          csum;

    assign line = sync_q[1];
    assign fall = prev_q & ~line;
    assign rise = ~prev_q & line;
    assign tick = (div_q == DW'(DIV - 1));

    // A sensor-driven phase ends in error once TIMEOUT_US ticks have elapsed in it.
    assign phase_to  = tick && (cnt_q >= CW'(TIMEOUT_US - 1));
    assign bit_val   = (cnt_q > CW'(BIT_THRESH_US));
    assign auto_fire = (AUTO_PERIOD_MS != 0) && tick && (auto_q == AW'(AUTO_LAST));

    assign div_d = tick ? '0 : div_q + 1'b1;

    always_comb begin
        csum = '0;
        for (int i = 1; i < NBYTES; i++) begin
            csum = csum + shreg_q[8*i +: 8];
        end
    end

    always_comb begin
        auto_d = '0;
        if (AUTO_PERIOD_MS != 0 && state_q == StIdle && tick) begin
            auto_d = (auto_q == AW'(AUTO_LAST)) ? '0 : auto_q + 1'b1;
        end else if (AUTO_PERIOD_MS != 0 && state_q == StIdle) begin
            auto_d = auto_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = (tick && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        eto_d    = eto_q;
        ecs_d    = ecs_q;

        unique case (state_q)
            StIdle: begin
                if (start || auto_fire) begin
                    eto_d   = 1'b0;
                    ecs_d   = 1'b0;
                    state_d = StStartLow;
                end
            end
            StStartLow: begin
                if (tick && cnt_q == CW'(START_LOW_US - 1)) begin
                    state_d = StRelWait;
                end
            end
            StRelWait: begin
                if (fall) begin
                    state_d = StRespLow;
                end else if (phase_to) begin
                    eto_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StRespLow: begin
                if (rise) begin
                    state_d = StRespHigh;
                end else if (phase_to) begin
                    eto_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StRespHigh: begin
                if (fall) begin
                    bitcnt_d = '0;
                    state_d  = StBitLow;
                end else if (phase_to) begin
                    eto_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StBitLow: begin
                if (rise) begin
                    state_d = StBitHigh;
                end else if (phase_to) begin
                    eto_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StBitHigh: begin
                if (fall) begin
                    shreg_d  = {shreg_q[NBITS-2:0], bit_val};
                    bitcnt_d = bitcnt_q + 1'b1;
                    state_d  = (bitcnt_q == BCW'(NBITS - 1)) ? StCheck : StBitLow;
                end else if (phase_to) begin
                    eto_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StCheck: begin
                if (csum == shreg_q[7:0]) begin
                    data_d  = shreg_q;
                    valid_d = 1'b1;
                end else begin
                    ecs_d = 1'b1;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Every state measures its own duration from zero, including the bit high time.
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            sync_q   <= '0;
            prev_q   <= 1'b0;
            div_q    <= '0;
            cnt_q    <= '0;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            data_q   <= '0;
            auto_q   <= '0;
            valid_q  <= 1'b0;
            eto_q    <= 1'b0;
            ecs_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= {sync_q[0], dth_in};
            prev_q   <= line;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            data_q   <= data_d;
            auto_q   <= auto_d;
            valid_q  <= valid_d;
            eto_q    <= eto_d;
            ecs_q    <= ecs_d;
        end
    end

    assign dth_oe       = (state_q == StStartLow);
    assign busy         = (state_q != StIdle);
    assign data_out     = data_q;
    assign data_valid   = valid_q;
    assign err_timeout  = eto_q;
    assign err_checksum = ecs_q;

endmodule
